// File: rtl/hba_arb_pkg.sv
// Shared types and helpers for the HBA round-robin arbiter.
// Provides the arbiter state encoding, owner index width and rotating first-one search.
package hba_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWNED,
        ST_DEAD
    } arb_state_t;

    localparam int unsigned OWNER_W = 4;
    localparam int unsigned MAX_REQ = 1 << OWNER_W;
    localparam int unsigned IDX_W   = OWNER_W + 1;

    // Returns {valid, index}: first set bit of req searching from last+1 upward, wrapping at n.
    function automatic logic [OWNER_W:0] next_rr(
        input logic [MAX_REQ-1:0] req,
        input logic [OWNER_W-1:0] last,
        input int unsigned        n
    );
        logic [OWNER_W:0] res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            if (i <= n) begin
                idx = {1'b0, last} + IDX_W'(i);
                if (idx >= IDX_W'(n)) begin
                    idx = idx - IDX_W'(n);
                end
                if (!res[OWNER_W] && req[idx[OWNER_W-1:0]]) begin
                    res = {1'b1, idx[OWNER_W-1:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hba_rr_picker.sv
// Combinational rotating priority encoder: first requester after 'last', with wrap.
// Generic enough to be shared with the interrupt controller.
module hba_rr_picker
    import hba_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] last,
    output logic               valid,
    output logic [OWNER_W-1:0] index
);

    logic [MAX_REQ-1:0] req_ext;
    logic [OWNER_W:0]   pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        pick           = next_rr(req_ext, last, N);
        valid          = pick[OWNER_W];
        index          = pick[OWNER_W-1:0];
    end

endmodule

// File: rtl/hba_arbiter_rr.sv
// Round-robin HBA bus arbiter with tenure limit and a dead cycle between owners.
// Define HBA_ARB_TIMEOUT_EN to add the select-without-ack timeout and synthesized ack.
module hba_arbiter_rr
    import hba_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned MAX_XFERS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   hba_clk,
    input  logic                   hba_reset,
    input  logic [NUM_MASTERS-1:0] hba_mrequest,
    input  logic                   hba_select,
    input  logic                   hba_xferack_slv,
    output logic [NUM_MASTERS-1:0] hba_mgrant,
    output logic                   hba_xferack,
    output logic [OWNER_W-1:0]     arb_owner,
    output logic                   timeout_err,
    output logic [OWNER_W-1:0]     timeout_master,
    input  logic                   err_clr
);

    localparam int unsigned CNT_W = (MAX_XFERS < 2) ? 1 : $clog2(MAX_XFERS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_XFERS);

    arb_state_t         state;
    logic [OWNER_W-1:0] last_q;
    logic [CNT_W-1:0]   xfer_cnt;
    logic               to_ack;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;
    logic               owner_req;
    logic               others_req;
    logic               xfer_seen;
    logic               cnt_full;

    hba_rr_picker #(
        .N (NUM_MASTERS)
    ) u_picker (
        .req   (hba_mrequest),
        .last  (last_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign hba_xferack = hba_xferack_slv | to_ack;

    always_comb begin
        owner_req  = |(hba_mrequest & hba_mgrant);
        others_req = |(hba_mrequest & ~hba_mgrant);
        xfer_seen  = hba_select & hba_xferack;
        cnt_full   = (MAX_XFERS != 0) && (xfer_cnt == CNT_MAX);
    end

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state      <= ST_IDLE;
            hba_mgrant <= '0;
            last_q     <= OWNER_W'(NUM_MASTERS - 1);
            xfer_cnt   <= '0;
            arb_owner  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        hba_mgrant <= NUM_MASTERS'(1) << pick_idx;
                        arb_owner  <= pick_idx;
                        last_q     <= pick_idx;
                        xfer_cnt   <= '0;
                        state      <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    // With MAX_XFERS=0, CNT_MAX is 0 so the counter never moves.
                    if (xfer_seen && (xfer_cnt != CNT_MAX)) begin
                        xfer_cnt <= xfer_cnt + 1'b1;
                    end
                    if (!hba_select && (!owner_req || (cnt_full && others_req))) begin
                        hba_mgrant <= '0;
                        state      <= ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef HBA_ARB_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer;
    logic             tmr_run;

    assign tmr_run = (state == ST_OWNED) && hba_select && !hba_xferack_slv;

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            timer          <= '0;
            to_ack         <= 1'b0;
            timeout_err    <= 1'b0;
            timeout_master <= '0;
        end else begin
            to_ack <= 1'b0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
            // A timeout in the same cycle overrides the clear above.
            if (!tmr_run) begin
                timer <= '0;
            end else if (timer == TMR_LAST) begin
                timer          <= '0;
                to_ack         <= 1'b1;
                timeout_err    <= 1'b1;
                timeout_master <= arb_owner;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign to_ack             = 1'b0;
    assign timeout_err        = 1'b0;
    assign timeout_master     = '0;
    assign unused_timeout_cfg = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule
